// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer: FSM state,
// register-index type and the per-latch enable/flush pair.
package hazard_ctrl_pkg;

  localparam int HZ_REG_W = 5;

  typedef logic [HZ_REG_W-1:0] regbits_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DWAIT   = 2'd1,
    HALTING = 2'd2,
    HALTED  = 2'd3
  } hzstate_t;

  // Control pair for one pipeline latch.
  typedef struct packed {
    logic en;
    logic flush;
  } pipe_ctrl_t;

  // Latch holds its contents.
  localparam pipe_ctrl_t LC_HOLD  = '{en: 1'b0, flush: 1'b0};
  // Latch captures the upstream stage.
  localparam pipe_ctrl_t LC_ADV   = '{en: 1'b1, flush: 1'b0};
  // Latch clears to a bubble.
  localparam pipe_ctrl_t LC_FLUSH = '{en: 1'b0, flush: 1'b1};
  // Both bits set: mem/wb during a data-cache wait, where flush wins.
  localparam pipe_ctrl_t LC_KILL  = '{en: 1'b1, flush: 1'b1};

endpackage

// File: rtl/hazard_ctrl_detect.sv
// Load-use comparator: the load in execute writes a register that the
// instruction in decode reads. Register 0 is never a real dependency.
module hazard_detect #(
  parameter int REG_W = 5
) (
  input  logic             dREN_E,
  input  logic [REG_W-1:0] wsel_E,
  input  logic [REG_W-1:0] rs_D,
  input  logic [REG_W-1:0] rt_D,
  output logic             stall
);

  assign stall = dREN_E && (wsel_E != '0) &&
                 ((wsel_E == rs_D) || (wsel_E == rt_D));

endmodule

// File: rtl/hazard_ctrl.sv
// Central pipeline sequencer for the 5-stage CPU. Drives pc/fd/de/em/mw
// enables and flushes and sequences data-cache waits and the halt drain.
// Optional statistics counters: define HAZARD_CTRL_STATS_EN.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dREN_M,
  input  logic             dWEN_M,
  input  logic             dREN_E,
  input  logic [REG_W-1:0] wsel_E,
  input  logic [REG_W-1:0] rs_D,
  input  logic [REG_W-1:0] rt_D,
  input  logic             redirect_E,
  input  logic             halt_M,
  input  logic             halt_W,
  output logic             pc_en,
  output logic             fd_en,
  output logic             fd_flush,
  output logic             de_en,
  output logic             de_flush,
  output logic             em_en,
  output logic             em_flush,
  output logic             mw_en,
  output logic             mw_flush,
  output logic             halt
`ifdef HAZARD_CTRL_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] dwait_cnt
`endif
);

  typedef logic [CNT_W-1:0] cnt_t;

  hzstate_t   state, state_nxt;
  logic       halt_q;
  logic       load_use;
  logic       dmem_wait;
  logic       mem_busy;
  logic       redirect_fl;
  pipe_ctrl_t fd_c, de_c, em_c, mw_c;

  hazard_detect #(.REG_W(REG_W)) u_detect (
    .dREN_E (dREN_E),
    .wsel_E (wsel_E),
    .rs_D   (rs_D),
    .rt_D   (rt_D),
    .stall  (load_use)
  );

  // An access issued this cycle that has not completed.
  assign dmem_wait = (dREN_M || dWEN_M) && !dhit;
  // Memory stage is still blocked, including the cycles spent in DWAIT.
  assign mem_busy  = dmem_wait || ((state == DWAIT) && !dhit);

  // State register and registered halt flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= RUN;
      halt_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == HALTING) && halt_W) halt_q <= 1'b1;
    end
  end

  // Next state: a pending memory access is always resolved before the
  // halt drain begins, so a store ahead of the halt still completes.
  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN: begin
        if (dmem_wait)   state_nxt = DWAIT;
        else if (halt_M) state_nxt = HALTING;
      end
      DWAIT: begin
        if (dhit) state_nxt = halt_M ? HALTING : RUN;
      end
      HALTING: begin
        if (halt_W) state_nxt = HALTED;
      end
      HALTED: state_nxt = HALTED;
    endcase
  end

  // Output mux. In DWAIT the hit cycle falls through to the RUN rules so
  // the completed access advances into writeback without an extra cycle.
  always_comb begin
    pc_en       = 1'b0;
    fd_c        = LC_HOLD;
    de_c        = LC_HOLD;
    em_c        = LC_HOLD;
    mw_c        = LC_HOLD;
    redirect_fl = 1'b0;
    unique case (state)
      RUN, DWAIT: begin
        if (mem_busy) begin
          mw_c = LC_KILL;
        end else if (redirect_E) begin
          // Redirect wins over load-use and icache miss: the younger
          // slots are discarded and fetch restarts at the target.
          pc_en       = 1'b1;
          fd_c        = LC_FLUSH;
          de_c        = LC_FLUSH;
          em_c        = LC_ADV;
          mw_c        = LC_ADV;
          redirect_fl = 1'b1;
        end else if (load_use || !ihit) begin
          de_c = LC_FLUSH;
          em_c = LC_ADV;
          mw_c = LC_ADV;
        end else begin
          pc_en = 1'b1;
          fd_c  = LC_ADV;
          de_c  = LC_ADV;
          em_c  = LC_ADV;
          mw_c  = LC_ADV;
        end
      end
      HALTING: begin
        if (dmem_wait) begin
          mw_c = LC_KILL;
        end else begin
          fd_c = LC_FLUSH;
          de_c = LC_FLUSH;
          em_c = LC_FLUSH;
          mw_c = LC_ADV;
        end
      end
      HALTED: ;
    endcase
  end

  assign fd_en    = fd_c.en;
  assign fd_flush = fd_c.flush;
  assign de_en    = de_c.en;
  assign de_flush = de_c.flush;
  assign em_en    = em_c.en;
  assign em_flush = em_c.flush;
  assign mw_en    = mw_c.en;
  assign mw_flush = mw_c.flush;
  assign halt     = halt_q;

`ifdef HAZARD_CTRL_STATS_EN
  cnt_t stall_q, flush_q, dwait_q;

  // Saturating statistics counters, frozen once the CPU has halted.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_q <= '0;
      flush_q <= '0;
      dwait_q <= '0;
    end else if (state != HALTED) begin
      if ((state == RUN) && !pc_en && (stall_q != '1))
        stall_q <= stall_q + cnt_t'(1);
      if (redirect_fl && (flush_q != '1))
        flush_q <= flush_q + cnt_t'(1);
      if ((state == DWAIT) && (dwait_q != '1))
        dwait_q <= dwait_q + cnt_t'(1);
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
  assign dwait_cnt = dwait_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by
// random traffic, all compared against a rule-level reference model.
module tb_hazard_ctrl;

  localparam int REG_W = 5;
  localparam int CNT_W = 32;

  // Expected control vectors {pc_en, fd_en,fd_flush, de_en,de_flush,
  // em_en,em_flush, mw_en,mw_flush}.
  localparam logic [8:0] C_ALL    = 9'b1_10_10_10_10;
  localparam logic [8:0] C_BUBBLE = 9'b0_00_01_10_10;
  localparam logic [8:0] C_REDIR  = 9'b1_01_01_10_10;
  localparam logic [8:0] C_FREEZE = 9'b0_00_00_00_11;
  localparam logic [8:0] C_DRAIN  = 9'b0_01_01_01_10;
  localparam logic [8:0] C_OFF    = 9'b0_00_00_00_00;

  logic CLK = 1'b0;
  logic RST, ihit, dhit, dREN_M, dWEN_M, dREN_E, redirect_E, halt_M, halt_W;
  logic [REG_W-1:0] wsel_E, rs_D, rt_D;
  logic pc_en, fd_en, fd_flush, de_en, de_flush, em_en, em_flush;
  logic mw_en, mw_flush, halt;
`ifdef HAZARD_CTRL_STATS_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt, dwait_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: which phase the CPU is in, plus expected counters.
  bit m_wait, m_drain, m_done, m_halt;
  logic [CNT_W-1:0] m_stall, m_flush, m_dwait;

  hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .dREN_M(dREN_M), .dWEN_M(dWEN_M), .dREN_E(dREN_E),
    .wsel_E(wsel_E), .rs_D(rs_D), .rt_D(rt_D),
    .redirect_E(redirect_E), .halt_M(halt_M), .halt_W(halt_W),
    .pc_en(pc_en), .fd_en(fd_en), .fd_flush(fd_flush),
    .de_en(de_en), .de_flush(de_flush), .em_en(em_en), .em_flush(em_flush),
    .mw_en(mw_en), .mw_flush(mw_flush), .halt(halt)
`ifdef HAZARD_CTRL_STATS_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .dwait_cnt(dwait_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic bit mem_blocked();
    return ((dREN_M || dWEN_M) && !dhit) || (m_wait && !dhit);
  endfunction

  function automatic logic [8:0] exp_ctrl();
    bit lu;
    lu = dREN_E && (wsel_E != 0) && (wsel_E == rs_D || wsel_E == rt_D);
    if (m_done)               return C_OFF;
    if (mem_blocked())        return C_FREEZE;
    if (m_drain)              return C_DRAIN;
    if (redirect_E)           return C_REDIR;
    if (lu || !ihit)          return C_BUBBLE;
    return C_ALL;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1;
  endfunction

  task automatic model_step(input logic [8:0] e);
    bit blocked;
    blocked = mem_blocked();
    if (RST) begin
      m_wait = 0; m_drain = 0; m_done = 0; m_halt = 0;
      m_stall = '0; m_flush = '0; m_dwait = '0;
      return;
    end
    if (m_done) return;
    if (!m_wait && !m_drain && !e[8]) m_stall = sat_inc(m_stall);
    if (!m_drain && !blocked && redirect_E) m_flush = sat_inc(m_flush);
    if (m_wait) m_dwait = sat_inc(m_dwait);
    if (m_drain) begin
      if (halt_W) begin m_drain = 0; m_done = 1; m_halt = 1; end
    end else if (m_wait) begin
      if (dhit) begin m_wait = 0; m_drain = halt_M; end
    end else if ((dREN_M || dWEN_M) && !dhit) begin
      m_wait = 1;
    end else if (halt_M) begin
      m_drain = 1;
    end
  endtask

  // Check outputs mid-cycle, then advance one clock and the model.
  task automatic tick(input string tag);
    logic [8:0] e, a;
    #2;
    e = exp_ctrl();
    a = {pc_en, fd_en, fd_flush, de_en, de_flush, em_en, em_flush, mw_en, mw_flush};
    checks++;
    assert (a === e) else begin
      failures++;
      $error("FAIL %s ctrl observed=%b expected=%b t=%0t", tag, a, e, $time);
    end
    checks++;
    assert (halt === m_halt) else begin
      failures++;
      $error("FAIL %s halt observed=%b expected=%b t=%0t", tag, halt, m_halt, $time);
    end
`ifdef HAZARD_CTRL_STATS_EN
    checks++;
    assert ({stall_cnt, flush_cnt, dwait_cnt} === {m_stall, m_flush, m_dwait}) else begin
      failures++;
      $error("FAIL %s cnt observed=%0d/%0d/%0d expected=%0d/%0d/%0d t=%0t", tag,
             stall_cnt, flush_cnt, dwait_cnt, m_stall, m_flush, m_dwait, $time);
    end
`endif
    @(posedge CLK);
    model_step(e);
    #1;
  endtask

  task automatic idle();
    RST = 0; ihit = 1; dhit = 0; dREN_M = 0; dWEN_M = 0; dREN_E = 0;
    redirect_E = 0; halt_M = 0; halt_W = 0; wsel_E = '0; rs_D = '0; rt_D = '0;
  endtask

  initial begin
    idle();
    RST = 1;
    @(posedge CLK);
    model_step(C_OFF);
    #1;
    tick("reset");
    RST = 0;
    tick("run_idle");

    // Load-use stalls exactly once; r0 never stalls.
    dREN_E = 1; wsel_E = 5'd8; rs_D = 5'd8; rt_D = 5'd3;
    tick("loaduse");
    dREN_E = 0;
    tick("loaduse_next");
    dREN_E = 1; wsel_E = 5'd0; rs_D = 5'd0;
    tick("loaduse_r0");
    idle();

    // Data-cache miss for 3 cycles, hit on the 4th.
    dREN_M = 1; dhit = 0;
    repeat (3) tick("dmiss");
    dhit = 1;
    tick("dmiss_hit");
    idle();
    tick("dmiss_after");

    // Redirect with simultaneous icache miss.
    redirect_E = 1; ihit = 0;
    tick("redir_imiss");
    idle();

    // Halt drain, then stay halted.
    halt_M = 1;
    tick("halt_m");
    halt_M = 0; halt_W = 1;
    tick("halting");
    halt_W = 0;
    repeat (10) tick("halted");
    RST = 1;
    tick("halt_reset");
    idle();

    // Store ahead of halt: wait for the store, then drain.
    dWEN_M = 1; halt_M = 1; dhit = 0;
    repeat (2) tick("st_halt_wait");
    dhit = 1;
    tick("st_halt_hit");
    idle(); halt_W = 1;
    tick("st_halting");
    halt_W = 0;
    tick("st_halted");
    RST = 1;
    tick("st_reset");
    idle();

    // Reset in the middle of a miss and in the middle of a drain.
    dREN_M = 1; dhit = 0;
    repeat (2) tick("dwait_pre_rst");
    RST = 1;
    tick("rst_dwait");
    idle();
    tick("after_rst_dwait");
    halt_M = 1;
    tick("halt_m2");
    halt_M = 0; RST = 1;
    tick("rst_halting");
    idle();
    tick("after_rst_halting");

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      int r;
      RST  = ($urandom_range(0, 99) == 0) || (m_done && $urandom_range(0, 5) == 0);
      ihit = ($urandom_range(0, 4) != 0);
      r = $urandom_range(0, 5);
      dREN_M = (r == 0);
      dWEN_M = (r == 1);
      dhit = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 1) begin
        dREN_E = ($urandom_range(0, 1) == 0); redirect_E = 0;
      end else begin
        redirect_E = ($urandom_range(0, 2) == 0); dREN_E = 0;
      end
      wsel_E = REG_W'($urandom_range(0, 3));
      rs_D   = REG_W'($urandom_range(0, 3));
      rt_D   = REG_W'($urandom_range(0, 3));
      halt_M = ($urandom_range(0, 24) == 0);
      halt_W = ($urandom_range(0, 2) == 0);
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
